// File: rtl/issue_queue_dual.sv
// issue_queue_dual: in-order dual-slot buffer between decode and issue.
// Accepts up to two decoded packets per cycle and presents the two oldest
// to issue, which may consume 0, 1 or 2 per cycle. i_flush empties the queue.
//
// Ports:
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   i_flush             synchronous flush; pointers and count cleared at edge
//   i_valid[1:0]        push-slot valid, bit0 = older packet
//   i_pkt0 / i_pkt1     push packets, slot 0 / slot 1
//   o_ready             queue can take two packets this cycle
//   o_valid[1:0]        head-slot valid, bit0 = oldest entry
//   o_pkt0 / o_pkt1     oldest / second-oldest entry
//   i_pop[1:0]          consumer takes head slots
//   o_count             current occupancy
//   o_stall_cnt         (only with ISSUE_QUEUE_STALL_CNT_EN) saturating count
//                       of cycles where slot 0 is offered but o_ready = 0
//
// Optional macro: ISSUE_QUEUE_STALL_CNT_EN adds the o_stall_cnt counter.
module issue_queue_dual #(
  parameter int unsigned  PKT_W = 216,
  parameter int unsigned  DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic [1:0]       i_valid,
  input  logic [PKT_W-1:0] i_pkt0,
  input  logic [PKT_W-1:0] i_pkt1,
  output logic             o_ready,
  output logic [1:0]       o_valid,
  output logic [PKT_W-1:0] o_pkt0,
  output logic [PKT_W-1:0] o_pkt1,
  input  logic [1:0]       i_pop,
  output logic [CNT_W-1:0] o_count
`ifdef ISSUE_QUEUE_STALL_CNT_EN
  ,
  output logic [31:0]      o_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_ready;
  logic             w_vld0;
  logic             w_vld1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_pop0;
  logic             w_pop1;
  logic [CNT_W-1:0] w_n_in;
  logic [CNT_W-1:0] w_n_out;
  logic [PTR_W-1:0] w_wr_ptr1;
  logic [PTR_W-1:0] w_rd_ptr1;

  // Handshake decode; ready looks only at registered occupancy
  always_comb begin
    w_ready   = (r_count <= CNT_W'(DEPTH - 2));
    w_vld0    = (r_count >= CNT_W'(1));
    w_vld1    = (r_count >= CNT_W'(2));
    w_acc0    = i_valid[0] & w_ready;
    w_acc1    = i_valid[1] & i_valid[0] & w_ready;
    w_pop0    = i_pop[0] & w_vld0;
    w_pop1    = i_pop[1] & i_pop[0] & w_vld1;
    w_n_in    = CNT_W'(w_acc0) + CNT_W'(w_acc1);
    w_n_out   = CNT_W'(w_pop0) + CNT_W'(w_pop1);
    w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
    w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
  end

  // Pointers and occupancy; pointer wrap is natural overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_in);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_out);
      r_count  <= r_count + w_n_in - w_n_out;
    end
  end

  // Packet storage; flush discards same-cycle pushes but keeps old contents
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (!i_flush) begin
      if (w_acc0) r_mem[r_wr_ptr]  <= i_pkt0;
      if (w_acc1) r_mem[w_wr_ptr1] <= i_pkt1;
    end
  end

`ifdef ISSUE_QUEUE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Back-pressure cycle counter, saturating; survives flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (i_valid[0] && !w_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_ready = w_ready;
  assign o_valid = {w_vld1, w_vld0};
  assign o_pkt0  = r_mem[r_rd_ptr];
  assign o_pkt1  = r_mem[w_rd_ptr1];
  assign o_count = r_count;

endmodule

// File: tb/tb_issue_queue_dual.sv
// Testbench for issue_queue_dual: directed vector table, hand sequences for
// wrap/flush/reset corners, and randomized traffic against a queue model.
module tb_issue_queue_dual;

  localparam int unsigned PKT_W = 216;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rstn;
  logic             i_flush;
  logic [1:0]       i_valid;
  logic [PKT_W-1:0] i_pkt0;
  logic [PKT_W-1:0] i_pkt1;
  logic             o_ready;
  logic [1:0]       o_valid;
  logic [PKT_W-1:0] o_pkt0;
  logic [PKT_W-1:0] o_pkt1;
  logic [1:0]       i_pop;
  logic [CNT_W-1:0] o_count;
`ifdef ISSUE_QUEUE_STALL_CNT_EN
  logic [31:0]      o_stall_cnt;
`endif

  issue_queue_dual #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_pkt0  (i_pkt0),
    .i_pkt1  (i_pkt1),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_pkt0  (o_pkt0),
    .o_pkt1  (o_pkt1),
    .i_pop   (i_pop),
    .o_count (o_count)
`ifdef ISSUE_QUEUE_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: plain queue of packets plus stall tally
  logic [PKT_W-1:0] mq[$];
  longint unsigned  m_stall;

  typedef struct {
    logic       flush;
    logic [1:0] valid;
    logic [1:0] pop;
    int         exp_count;
    logic       exp_ready;
    logic [1:0] exp_valid;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt();
    logic [PKT_W-1:0] p;
    p = '0;
    for (int i = 0; i < 7; i++) p = (p << 32) | PKT_W'($urandom);
    return p;
  endfunction

  // Compare DUT outputs with the model state
  task automatic check_model();
    int n;
    n = mq.size();
    chk("count", 256'(o_count), 256'(n));
    chk("ready", 256'(o_ready), 256'(n <= int'(DEPTH) - 2));
    chk("valid", 256'(o_valid), 256'({n >= 2, n >= 1}));
    if (n >= 1) chk("pkt0", 256'(o_pkt0), 256'(mq[0]));
    if (n >= 2) chk("pkt1", 256'(o_pkt1), 256'(mq[1]));
`ifdef ISSUE_QUEUE_STALL_CNT_EN
    chk("stall_cnt", 256'(o_stall_cnt), 256'(m_stall));
`endif
  endtask

  // One clock of traffic: check, drive, advance model, go idle after the edge
  task automatic step(input logic fl, input logic [1:0] v, input logic [1:0] pp);
    logic [PKT_W-1:0] a;
    logic [PKT_W-1:0] b;
    int  n;
    bit  rdy;
    @(negedge clk);
    check_model();
    a = rand_pkt();
    b = rand_pkt();
    i_flush = fl;
    i_valid = v;
    i_pop   = pp;
    i_pkt0  = a;
    i_pkt1  = b;
    n   = mq.size();
    rdy = (n <= int'(DEPTH) - 2);
    if (v[0] && !rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      if (pp[0] && n >= 1) void'(mq.pop_front());
      if (pp[1] && pp[0] && n >= 2) void'(mq.pop_front());
      if (v[0] && rdy) mq.push_back(a);
      if (v[1] && v[0] && rdy) mq.push_back(b);
    end
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 2'b00;
    i_pop   = 2'b00;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_stall  = 0;
    rstn     = 1'b0;
    i_flush  = 1'b0;
    i_valid  = 2'b00;
    i_pop    = 2'b00;
    i_pkt0   = '0;
    i_pkt1   = '0;

    // {flush, valid, pop, count after edge, ready after, valid after}
    vecs[0]  = '{1'b0, 2'b11, 2'b00, 2, 1'b1, 2'b11};  // dual push from empty
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 4, 1'b1, 2'b11};
    vecs[2]  = '{1'b0, 2'b11, 2'b00, 6, 1'b1, 2'b11};
    vecs[3]  = '{1'b0, 2'b11, 2'b00, 8, 1'b0, 2'b11};  // full
    vecs[4]  = '{1'b0, 2'b11, 2'b00, 8, 1'b0, 2'b11};  // push while full ignored
    vecs[5]  = '{1'b0, 2'b00, 2'b11, 6, 1'b1, 2'b11};
    vecs[6]  = '{1'b0, 2'b00, 2'b01, 5, 1'b1, 2'b11};
    vecs[7]  = '{1'b0, 2'b00, 2'b10, 5, 1'b1, 2'b11};  // pop 10 ignored
    vecs[8]  = '{1'b0, 2'b10, 2'b00, 5, 1'b1, 2'b11};  // valid 10 writes nothing
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 5, 1'b1, 2'b11};
    vecs[10] = '{1'b1, 2'b11, 2'b01, 0, 1'b1, 2'b00};  // flush beats push/pop
    vecs[11] = '{1'b0, 2'b01, 2'b00, 1, 1'b1, 2'b01};
    vecs[12] = '{1'b0, 2'b00, 2'b11, 0, 1'b1, 2'b00};  // pop 2 with 1 valid

    #12;
    chk("rst_valid", 256'(o_valid), 256'(2'b00));
    chk("rst_ready", 256'(o_ready), 256'(1'b1));
    chk("rst_count", 256'(o_count), 256'(0));
    chk("rst_pkt0", 256'(o_pkt0), 256'(0));
    chk("rst_pkt1", 256'(o_pkt1), 256'(0));
    rstn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].flush, vecs[i].valid, vecs[i].pop);
      #1;
      chk($sformatf("vec%0d_count", i), 256'(o_count), 256'(vecs[i].exp_count));
      chk($sformatf("vec%0d_ready", i), 256'(o_ready), 256'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_valid", i), 256'(o_valid), 256'(vecs[i].exp_valid));
    end

    // Fill to 7, then steady push-2/pop-2 across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    #1;
    chk("fill7_count", 256'(o_count), 256'(7));
    for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 2'b11);

    // Count 5, flush with push 2 and pop 1
    step(1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    #1;
    chk("pre_flush_count", 256'(o_count), 256'(5));
    step(1'b1, 2'b11, 2'b01);
    #1;
    chk("flush_count", 256'(o_count), 256'(0));
    chk("flush_valid", 256'(o_valid), 256'(2'b00));
    chk("flush_ready", 256'(o_ready), 256'(1'b1));

    // Randomized traffic, including illegal slot patterns and rare flushes
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), 2'($urandom), 2'($urandom));
    end

    // Asynchronous reset in the middle of a busy cycle
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b00);
    @(negedge clk);
    i_valid = 2'b11;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_count", 256'(o_count), 256'(0));
    chk("mid_rst_valid", 256'(o_valid), 256'(2'b00));
    chk("mid_rst_ready", 256'(o_ready), 256'(1'b1));
    chk("mid_rst_pkt0", 256'(o_pkt0), 256'(0));
`ifdef ISSUE_QUEUE_STALL_CNT_EN
    chk("mid_rst_stall", 256'(o_stall_cnt), 256'(0));
`endif
    mq.delete();
    m_stall = 0;
    i_valid = 2'b00;
    #10;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 2'b11, 2'b01);
    @(negedge clk);
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
